instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage for the LEGv8 single-issue pipeline. Holds the program counter, drives the word address into the combinational instruction ROM, and registers each returned 32-bit instruction with its PC into the IF/ID pipeline register for the decoder. Supports decoder back-pressure, branch redirect with flush, and a halt state entered when the ROM returns the all-zero default word.

## Interface
- RESET_PC, 32'd0: PC value loaded on reset.
- HALT_ON_ZERO, 1: 1 = an instruction word of 32'h0000_0000 halts fetch; 0 = it is delivered as a normal instruction.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- rom_addr  output  32  byte address to ROM; combinationally equal to pc.
- rom_data  input  32  instruction word from ROM, same cycle as rom_addr.
- redirect  input  1  branch taken; load redirect_pc and flush IF/ID.
- redirect_pc  input  32  branch target; bits [1:0] are ignored and forced to 00.
- id_ready  input  1  decoder accepts the IF/ID contents this cycle.
- if_id_valid  output  1  IF/ID register holds a live instruction.
- if_id_instr  output  32  registered instruction word.
- if_id_pc  output  32  registered PC of if_id_instr.
- halted  output  1  fetch is in HALT.

## Operation
- State machine has two states:
  - RUN: fetching.
  - HALT: pc frozen and no new instructions captured.
- load = !if_id_valid || id_ready. The register refills when it is empty or being consumed, so bubbles collapse.
- Priority per cycle is redirect > halt detection > normal fetch > hold.
- redirect=1, in any state:
  - pc <= {redirect_pc[31:2],2'b00}
  - if_id_valid <= 0, even if id_ready=0, because the held instruction is squashed.
  - state <= RUN.
- RUN with load=1 and (rom_data != 0 or HALT_ON_ZERO=0):
  - if_id_instr <= rom_data
  - if_id_pc <= pc
  - if_id_valid <= 1
  - pc <= pc+4
- RUN with load=1, HALT_ON_ZERO=1 and rom_data == 0:
  - state <= HALT, if_id_valid <= 0, pc holds.
  - The zero word is never delivered.
- RUN with load=0 (stall): pc, if_id_* and state all hold. rom_addr stays stable.
- HALT without redirect:
  - pc holds.
  - if_id_valid <= 0 once id_ready=1. It is already 0 from the transition.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- halted = (state == HALT).

## Timing
- Reset (asynchronous, immediate):
  - pc = RESET_PC, state = RUN.
  - if_id_valid = 0, if_id_instr = 0, if_id_pc = 0, halted = 0.
  - rom_addr = RESET_PC while reset is asserted.
- Fetch latency is one cycle. The word at rom_addr in cycle n appears on if_id_instr after edge n+1.
- Throughput is one instruction per cycle while id_ready=1.
- Redirect penalty: the edge that samples redirect=1 produces if_id_valid=0. The target instruction is valid after the following edge.
- Redirect together with id_ready=0 still flushes. Redirect together with a zero rom_data does not halt.
- Deasserting reset mid-stream discards the IF/ID contents. Fetch restarts at RESET_PC on the first edge after release.
- halted asserts on the edge that detects the zero word and deasserts on the edge that samples redirect.

## Test plan
- **Reset:** assert reset mid-run with if_id_valid=1 -> outputs clear immediately, rom_addr=0. Release reset -> the next edge gives if_id_instr=32'h913E8021 (ADDI X1,X1,4000), if_id_pc=0, if_id_valid=1.
- **Straight-line run**, id_ready=1 against the six-entry ROM:
  - edges 1-6 deliver PCs 0,4,8,12,16,20.
  - Edge 2 gives 32'h913E8042.
  - Edge 7 sees rom_data=0 at pc=24 -> halted=1, if_id_valid=0, rom_addr stays 24 for 10 more cycles.
- **Stall:** drop id_ready for 3 cycles while if_id_pc=8 -> if_id_pc stays 8 and rom_addr stays 12. Raise id_ready -> the next edge gives if_id_pc=12.
- **Redirect:**
  - At if_id_pc=4, apply redirect=1 with redirect_pc=32'd17 and id_ready=0 -> if_id_valid=0 and pc=16.
  - The next edge gives if_id_instr=32'hD2800281 (MOVZ X1,20) at if_id_pc=16.
- **Leave HALT:** from HALT at pc=24, apply redirect to 0 -> halted=0 and the run restarts at 32'h913E8021.
- **HALT_ON_ZERO=0:** the zero word at 24 is delivered with valid=1, pc advances to 28, and halted stays 0. Also cover wrap: set RESET_PC=32'hFFFF_FFFC with HALT_ON_ZERO=0 -> the next pc is 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch -- LEGv8 instruction-fetch stage.
//
// Holds the program counter and drives it as the byte address of a
// combinational instruction ROM. Each returned word is registered, together
// with its PC, into the IF/ID pipeline register for the decoder. Supports
// decoder back-pressure, branch redirect with flush, and a halt state that is
// entered when the ROM returns the all-zero default word.
//
// State table:
//   state  | meaning
//   S_RUN  | fetching one word per cycle whenever IF/ID can accept it
//   S_HALT | pc frozen, no new instructions captured until a redirect
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset
//   rom_addr_o     byte address to ROM (equal to pc)
//   rom_data_i     instruction word from ROM, same cycle as rom_addr_o
//   redirect_i     branch taken: load redirect_pc_i and flush IF/ID
//   redirect_pc_i  branch target, bits [1:0] ignored
//   id_ready_i     decoder consumes IF/ID contents this cycle
//   if_id_valid_o  IF/ID holds a live instruction
//   if_id_instr_o  registered instruction word
//   if_id_pc_o     registered PC of if_id_instr_o
//   halted_o       fetch is in HALT
module instr_fetch #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic        halted_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] ifid_pc_q;

  logic        load_d;
  logic        zero_hit_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] redirect_tgt_d;
  logic        unused_pc_lsbs;

  // IF/ID refills when empty or being consumed, so bubbles collapse.
  assign load_d         = !valid_q || id_ready_i;
  assign zero_hit_d     = HALT_ON_ZERO && (rom_data_i == 32'h0000_0000);
  assign pc_plus4_d     = pc_q + 32'd4;  // modulo 2^32, wrap is silent
  assign redirect_tgt_d = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0000_0000;
      ifid_pc_q <= 32'h0000_0000;
    end else if (redirect_i) begin
      // Redirect wins over everything, including a stalled decoder and a
      // zero word on the ROM bus: the held instruction is squashed.
      state_q <= S_RUN;
      pc_q    <= redirect_tgt_d;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (load_d) begin
            if (zero_hit_d) begin
              // The zero word is never delivered; pc stays on it.
              state_q <= S_HALT;
              valid_q <= 1'b0;
            end else begin
              instr_q   <= rom_data_i;
              ifid_pc_q <= pc_q;
              valid_q   <= 1'b1;
              pc_q      <= pc_plus4_d;
            end
          end
        end
        S_HALT: begin
          if (id_ready_i) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  assign rom_addr_o    = pc_q;
  assign if_id_valid_o = valid_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign halted_o      = (state_q == S_HALT);

endmodule
